ip_ram_initiator: RTL and testbench
===================================

Name: ip_ram_initiator

Overview:
- Bus initiator for the 4K x 32-bit logger RAM; the RAM is the responder on bus_address/bus_valid/bus_ready/bus_write/bus_wdata/bus_rdata/bus_rdata_en.
- Takes captured log words from the capture logic and writes them into RAM as a 4096-entry ring.
- Serves random-address readback requests from the host dump logic.
- Sits between the capture/dump logic and the RAM.

Parameters:
- ADDR_W, 12, RAM word-address width; ring depth is 2^ADDR_W.
- TIMEOUT_CYCLES, 15, read-wait limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous pulse: zero wr_ptr and wrapped
- log_valid  in  1  log word offered
- log_data  in  32  log word
- log_ready  out  1  log word accepted this cycle
- rd_req  in  1  readback request
- rd_address  in  12  readback word address
- rd_ready  out  1  readback request accepted this cycle
- rd_ack  out  1  one-cycle pulse: rd_data valid
- rd_data  out  32  readback word
- rd_error  out  1  with rd_ack: read timed out (optional feature only)
- wr_ptr  out  12  next ring write address
- wrapped  out  1  ring has wrapped at least once since clr or reset
- bus_address  out  12  to RAM
- bus_valid  out  1  to RAM
- bus_ready  in  1  from RAM
- bus_write  out  1  to RAM
- bus_wdata  out  32  to RAM
- bus_rdata  in  32  from RAM
- bus_rdata_en  in  1  from RAM

Behaviour:
- Reset (async, active-high): all outputs 0; state ST_IDLE; bus_valid drops immediately; any in-flight transfer is abandoned.
- All bus outputs are registered.
- log_ready = (state==ST_IDLE) & log_valid.
- rd_ready = (state==ST_IDLE) & !log_valid & rd_req. Writes have priority so capture is never stalled by a dump.
- ST_IDLE:
  - on log_valid: bus_address<=wr_ptr, bus_wdata<=log_data, bus_write<=1, bus_valid<=1; go ST_WRITE.
  - else on rd_req: bus_address<=rd_address, bus_write<=0, bus_valid<=1; go ST_READ_REQ.
- ST_WRITE: hold all bus outputs until a cycle with bus_ready=1. At that edge: bus_valid<=0, bus_write<=0, wr_ptr<=wr_ptr+1 (mod 4096); go ST_IDLE.
- Wrap: if wr_ptr==4095 at write completion, wr_ptr becomes 0 and wrapped<=1. The oldest entry is overwritten; there is no full stall.
- ST_READ_REQ: hold until bus_ready=1. At that edge: bus_valid<=0; go ST_READ_WAIT.
- ST_READ_WAIT: in the first cycle with bus_rdata_en=1: rd_data<=bus_rdata, rd_ack<=1 for one cycle; go ST_IDLE.
  - bus_rdata_en outside ST_READ_WAIT is ignored.
- rd_data holds its value until the next rd_ack.
- Latency with bus_ready tied 1:
  - write: log_ready to next log_ready is 2 cycles (max 1 word per 2 cycles).
  - read: rd_ready edge to rd_ack high is 3 cycles.
- bus_wdata is 0 outside ST_WRITE.
- clr:
  - Any cycle: wr_ptr<=0, wrapped<=0.
  - If a write completes in the same cycle, the write still lands at its latched address, but clr wins: wr_ptr=0, not 1.
  - clr does not disturb reads.
- No combinational path from bus_* inputs to bus_* outputs.

Optional Feature:
- Macro: RAM_INITIATOR_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to ST_READ_WAIT and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES with no bus_rdata_en: rd_data<=32'hFFFF_FFFF, rd_error<=1 and rd_ack<=1 for one cycle; go ST_IDLE.
  - A normal completion drives rd_error=0.
- Undefined:
  - No counter; ST_READ_WAIT waits indefinitely.
  - rd_error is tied 0.

Test Plan:
- Reset release, then log_valid with log_data=32'h0000_00A5, bus_ready=1:
  - bus_valid=1, bus_write=1, bus_address=0, bus_wdata=A5 for one cycle.
  - Then wr_ptr=1.
- Write 3 words 11/22/33, then rd_req at addresses 0, 1, 2:
  - Each rd_ack arrives 3 cycles after rd_ready.
  - rd_data is 11, 22, 33 in order.
- 4097 writes:
  - wr_ptr=1 and wrapped=1.
  - Reading address 0 returns word #4097.
- log_valid and rd_req asserted together:
  - write issues first; rd_ready waits one idle cycle, then read completes.
- Hold bus_ready=0 for 5 cycles during a write:
  - bus_valid/address/wdata stable for 6 cycles; wr_ptr increments once.
  - Assert reset mid-stall: bus_valid=0 immediately, wr_ptr=0.
- With RAM_INITIATOR_TIMEOUT_EN, suppress bus_rdata_en:
  - rd_ack=1, rd_error=1, rd_data=32'hFFFF_FFFF, 15 cycles after entering ST_READ_WAIT.
- Without the macro, the same stimulus leaves the block hung in ST_READ_WAIT.

Source files
------------

// File: rtl/ip_ram_initiator.sv
// ip_ram_initiator: bus initiator for the 4K x 32 logger RAM.
// Writes captured log words into RAM as a ring (write has priority) and
// serves random-address readback requests from the host dump logic.
// Optional build macro RAM_INITIATOR_TIMEOUT_EN adds a read-wait timeout
// that completes a stuck read with rd_error=1 and rd_data=all ones.
module ip_ram_initiator #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              log_valid,
  input  logic [31:0]       log_data,
  output logic              log_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_address,
  output logic              rd_ready,
  output logic              rd_ack,
  output logic [31:0]       rd_data,
  output logic              rd_error,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic [ADDR_W-1:0] bus_address,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_write,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rdata_en
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_WAIT
  } state_t;

  state_t state;

  // The wait counter is only 4 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..15");
  end

  // Handshakes are decided from the registered state only; a pending log
  // word always wins over a readback so capture never stalls behind a dump.
  assign log_ready = (state == ST_IDLE) && log_valid;
  assign rd_ready  = (state == ST_IDLE) && !log_valid && rd_req;

`ifdef RAM_INITIATOR_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] wait_cnt;
`else
  assign rd_error = 1'b0;
`endif

  // Main controller: owns every registered bus output, the ring pointer
  // and the readback result; clr is applied last so it beats a completing write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bus_address <= '0;
      bus_valid   <= 1'b0;
      bus_write   <= 1'b0;
      bus_wdata   <= '0;
      rd_ack      <= 1'b0;
      rd_data     <= '0;
      wr_ptr      <= '0;
      wrapped     <= 1'b0;
`ifdef RAM_INITIATOR_TIMEOUT_EN
      wait_cnt    <= '0;
      rd_error    <= 1'b0;
`endif
    end else begin
      rd_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (log_valid) begin
            bus_address <= wr_ptr;
            bus_wdata   <= log_data;
            bus_write   <= 1'b1;
            bus_valid   <= 1'b1;
            state       <= ST_WRITE;
          end else if (rd_req) begin
            bus_address <= rd_address;
            bus_write   <= 1'b0;
            bus_valid   <= 1'b1;
            state       <= ST_READ_REQ;
          end
        end
        ST_WRITE: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            bus_wdata <= '0;
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == '1) begin
              wrapped <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        ST_READ_REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
`ifdef RAM_INITIATOR_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            state     <= ST_READ_WAIT;
          end
        end
        ST_READ_WAIT: begin
          if (bus_rdata_en) begin
            rd_data  <= bus_rdata;
            rd_ack   <= 1'b1;
`ifdef RAM_INITIATOR_TIMEOUT_EN
            rd_error <= 1'b0;
`endif
            state    <= ST_IDLE;
          end
`ifdef RAM_INITIATOR_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            rd_data  <= '1;
            rd_error <= 1'b1;
            rd_ack   <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
      if (clr) begin
        wr_ptr  <= '0;
        wrapped <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ip_ram_initiator.sv
// tb_ip_ram_initiator: self-checking bench for ip_ram_initiator with a
// behavioural RAM responder (2-cycle read latency) and a ring reference model.
// Build with RAM_INITIATOR_TIMEOUT_EN to exercise the read timeout instead
// of the default indefinite read wait.
module tb_ip_ram_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic        log_valid = 1'b0;
  logic [31:0] log_data = '0;
  logic        log_ready;
  logic        rd_req = 1'b0;
  logic [11:0] rd_address = '0;
  logic        rd_ready;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_error;
  logic [11:0] wr_ptr;
  logic        wrapped;
  logic [11:0] bus_address;
  logic        bus_valid;
  logic        bus_ready = 1'b1;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_rdata_en = 1'b0;

  logic        suppress_rdata = 1'b0;
  logic [31:0] ram [4096];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_pend_data = '0;

  logic [31:0] ref_mem [4096];
  bit          ref_valid [4096];
  int          exp_ptr = 0;
  bit          exp_wrapped = 1'b0;

  int checks = 0;
  int passed = 0;

  ip_ram_initiator #(.ADDR_W(12), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .log_valid(log_valid), .log_data(log_data), .log_ready(log_ready),
    .rd_req(rd_req), .rd_address(rd_address), .rd_ready(rd_ready),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_error(rd_error),
    .wr_ptr(wr_ptr), .wrapped(wrapped),
    .bus_address(bus_address), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_write(bus_write), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
  );

  always #5 clk = ~clk;

  // RAM responder: stores accepted writes, returns read data two edges after acceptance
  always @(posedge clk) begin
    rd_pend <= 1'b0;
    if (bus_valid && bus_ready) begin
      if (bus_write) begin
        ram[bus_address] <= bus_wdata;
      end else begin
        rd_pend      <= 1'b1;
        rd_pend_data <= ram[bus_address];
      end
    end
    bus_rdata_en <= rd_pend && !suppress_rdata;
    bus_rdata    <= rd_pend_data;
  end

  task automatic model_write(input logic [31:0] d);
    ref_mem[exp_ptr]   = d;
    ref_valid[exp_ptr] = 1'b1;
    exp_ptr = (exp_ptr + 1) % 4096;
    if (exp_ptr == 0) exp_wrapped = 1'b1;
  endtask

  task automatic model_clr();
    exp_ptr     = 0;
    exp_wrapped = 1'b0;
  endtask

  function automatic logic [11:0] pick_addr();
    int a;
    a = $urandom_range(0, 4095);
    if (!ref_valid[a]) a = (exp_ptr + 4095) % 4096;
    return 12'(a);
  endfunction

  task automatic write_word(input logic [31:0] d);
    int n;
    n = 0;
    log_valid = 1'b1; log_data = d; #1;
    while (!log_ready) begin
      if (n > 50) begin
        $display("[TB] FAIL write_accept: log_ready=%0b, required 1", log_ready);
        $fatal(1);
      end
      @(negedge clk); #1; n++;
    end
    @(negedge clk); log_valid = 1'b0; log_data = '0;
    @(negedge clk);
    model_write(d);
  endtask

  task automatic read_word(input logic [11:0] a, output logic [31:0] data,
                           output logic err, output int lat, output logic acked);
    int n;
    n = 0;
    rd_req = 1'b1; rd_address = a; #1;
    while (!rd_ready) begin
      if (n > 50) begin
        $display("[TB] FAIL read_accept: rd_ready=%0b, required 1", rd_ready);
        $fatal(1);
      end
      @(negedge clk); #1; n++;
    end
    @(negedge clk); rd_req = 1'b0;
    lat = 0;
    while (!rd_ack && lat < 60) begin
      @(negedge clk); lat++;
    end
    acked = rd_ack; data = rd_data; err = rd_error;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if ({bus_valid, bus_write, bus_address, bus_wdata} !== 46'd0) $display("[TB] FAIL reset_bus: got %h required 0", {bus_valid, bus_write, bus_address, bus_wdata}); else passed++;
    checks++; if ({rd_ack, rd_error, rd_data, wr_ptr, wrapped, log_ready, rd_ready} !== 49'd0) $display("[TB] FAIL reset_outputs: got %h required 0", {rd_ack, rd_error, rd_data, wr_ptr, wrapped, log_ready, rd_ready}); else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus_valid, wr_ptr, wrapped} !== 14'd0) $display("[TB] FAIL reset_release: got %h required 0", {bus_valid, wr_ptr, wrapped}); else passed++;
  endtask

  task automatic test_first_write();
    log_valid = 1'b1; log_data = 32'h0000_00A5; #1;
    checks++; if (log_ready !== 1'b1) $display("[TB] FAIL first_log_ready: got %b required 1", log_ready); else passed++;
    @(negedge clk); log_valid = 1'b0; log_data = '0;
    checks++; if ({bus_valid, bus_write, bus_address, bus_wdata} !== {1'b1, 1'b1, 12'h000, 32'h0000_00A5}) $display("[TB] FAIL first_write_bus: got %h required %h", {bus_valid, bus_write, bus_address, bus_wdata}, {1'b1, 1'b1, 12'h000, 32'h0000_00A5}); else passed++;
    @(negedge clk);
    model_write(32'h0000_00A5);
    checks++; if ({bus_valid, bus_write, bus_wdata} !== 34'd0) $display("[TB] FAIL first_write_idle: got %h required 0", {bus_valid, bus_write, bus_wdata}); else passed++;
    checks++; if (wr_ptr !== 12'd1) $display("[TB] FAIL first_write_ptr: got %0d required 1", wr_ptr); else passed++;
  endtask

  task automatic test_readback();
    logic [31:0] words [3];
    logic [31:0] d;
    logic e, ack;
    int lat;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    clr = 1'b1; @(negedge clk); clr = 1'b0; model_clr();
    checks++; if ({wr_ptr, wrapped} !== 13'd0) $display("[TB] FAIL clr_idle: got %h required 0", {wr_ptr, wrapped}); else passed++;
    for (int i = 0; i < 3; i++) write_word(words[i]);
    for (int i = 0; i < 3; i++) begin
      read_word(12'(i), d, e, lat, ack);
      checks++; if (!ack || lat != 3 || d !== words[i] || e !== 1'b0) $display("[TB] FAIL readback_%0d: ack=%b lat=%0d data=%h err=%b required ack=1 lat=3 data=%h err=0", i, ack, lat, d, e, words[i]); else passed++;
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [11:0] a;
    logic e, ack;
    int lat;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        write_word($urandom);
      end else begin
        a = pick_addr();
        read_word(a, d, e, lat, ack);
        checks++; if (!ack || lat != 3 || d !== ref_mem[a]) $display("[TB] FAIL random_read@%h: ack=%b lat=%0d data=%h required ack=1 lat=3 data=%h", a, ack, lat, d, ref_mem[a]); else passed++;
      end
    end
    checks++; if ({wr_ptr, wrapped} !== {12'(exp_ptr), exp_wrapped}) $display("[TB] FAIL random_ptr: got %h/%b required %h/%b", wr_ptr, wrapped, 12'(exp_ptr), exp_wrapped); else passed++;
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic [11:0] a;
    int lat;
    d = $urandom; a = 12'(exp_ptr);
    log_valid = 1'b1; log_data = d; rd_req = 1'b1; rd_address = a; #1;
    checks++; if ({log_ready, rd_ready} !== 2'b10) $display("[TB] FAIL prio_first: got ready=%b%b required 10", log_ready, rd_ready); else passed++;
    @(negedge clk); log_valid = 1'b0; log_data = '0; #1;
    checks++; if (rd_ready !== 1'b0) $display("[TB] FAIL prio_busy: got rd_ready=%b required 0", rd_ready); else passed++;
    @(negedge clk); model_write(d); #1;
    checks++; if (rd_ready !== 1'b1) $display("[TB] FAIL prio_read_accept: got rd_ready=%b required 1", rd_ready); else passed++;
    @(negedge clk); rd_req = 1'b0;
    lat = 0;
    while (!rd_ack && lat < 60) begin @(negedge clk); lat++; end
    checks++; if (!rd_ack || lat != 3 || rd_data !== d) $display("[TB] FAIL prio_read_data: ack=%b lat=%0d data=%h required ack=1 lat=3 data=%h", rd_ack, lat, rd_data, d); else passed++;
  endtask

  task automatic test_clr();
    logic [31:0] d, got;
    logic [11:0] a;
    logic e, ack;
    int lat;
    d = $urandom; a = 12'(exp_ptr);
    log_valid = 1'b1; log_data = d; #1;
    @(negedge clk); log_valid = 1'b0; log_data = '0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    ref_mem[a] = d; ref_valid[a] = 1'b1; model_clr();
    checks++; if ({wr_ptr, wrapped} !== 13'd0) $display("[TB] FAIL clr_vs_write_ptr: got %h/%b required 0/0", wr_ptr, wrapped); else passed++;
    read_word(a, got, e, lat, ack);
    checks++; if (!ack || got !== d) $display("[TB] FAIL clr_vs_write_data@%h: ack=%b data=%h required ack=1 data=%h", a, ack, got, d); else passed++;
    rd_req = 1'b1; rd_address = a; #1;
    @(negedge clk); rd_req = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    lat = 1;
    while (!rd_ack && lat < 60) begin @(negedge clk); lat++; end
    checks++; if (!rd_ack || lat != 3 || rd_data !== d) $display("[TB] FAIL clr_during_read: ack=%b lat=%0d data=%h required ack=1 lat=3 data=%h", rd_ack, lat, rd_data, d); else passed++;
  endtask

  task automatic test_stall_reset();
    logic [31:0] d;
    logic [11:0] a;
    int stable_bad;
    d = $urandom; a = 12'(exp_ptr); stable_bad = 0;
    log_valid = 1'b1; log_data = d; #1;
    @(negedge clk); log_valid = 1'b0; log_data = '0; bus_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ({bus_valid, bus_write, bus_address, bus_wdata} !== {1'b1, 1'b1, a, d}) stable_bad++;
      if (i < 5) @(negedge clk);
    end
    checks++; if (stable_bad != 0) $display("[TB] FAIL stall_stable: %0d unstable cycles, required 0", stable_bad); else passed++;
    checks++; if (wr_ptr !== a) $display("[TB] FAIL stall_ptr_hold: got %h required %h", wr_ptr, a); else passed++;
    bus_ready = 1'b1;
    @(negedge clk); model_write(d);
    @(negedge clk); @(negedge clk);
    checks++; if ({bus_valid, wr_ptr} !== {1'b0, 12'(exp_ptr)}) $display("[TB] FAIL stall_complete: got valid=%b ptr=%h required valid=0 ptr=%h", bus_valid, wr_ptr, 12'(exp_ptr)); else passed++;
    log_valid = 1'b1; log_data = $urandom; #1;
    @(negedge clk); log_valid = 1'b0; log_data = '0; bus_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus_valid, bus_write, bus_wdata, wr_ptr, wrapped} !== 47'd0) $display("[TB] FAIL reset_mid_stall: got %h required 0", {bus_valid, bus_write, bus_wdata, wr_ptr, wrapped}); else passed++;
    @(negedge clk); reset = 1'b0; bus_ready = 1'b1; model_clr();
  endtask

  task automatic test_wrap();
    logic [31:0] d, last;
    logic e, ack;
    int lat;
    last = '0;
    clr = 1'b1; @(negedge clk); clr = 1'b0; model_clr();
    for (int i = 1; i <= 4097; i++) begin
      last = $urandom;
      write_word(last);
      if (i == 4095) begin
        checks++; if ({wr_ptr, wrapped} !== {12'd4095, 1'b0}) $display("[TB] FAIL wrap_before: got %0d/%b required 4095/0", wr_ptr, wrapped); else passed++;
      end
      if (i == 4096) begin
        checks++; if ({wr_ptr, wrapped} !== {12'd0, 1'b1}) $display("[TB] FAIL wrap_at: got %0d/%b required 0/1", wr_ptr, wrapped); else passed++;
      end
    end
    checks++; if ({wr_ptr, wrapped} !== {12'(exp_ptr), exp_wrapped} || exp_ptr != 1) $display("[TB] FAIL wrap_after: got %0d/%b required 1/1", wr_ptr, wrapped); else passed++;
    read_word(12'd0, d, e, lat, ack);
    checks++; if (!ack || d !== last) $display("[TB] FAIL wrap_read0: ack=%b data=%h required ack=1 data=%h", ack, d, last); else passed++;
    read_word(12'd1, d, e, lat, ack);
    checks++; if (!ack || d !== ref_mem[1]) $display("[TB] FAIL wrap_read1: ack=%b data=%h required ack=1 data=%h", ack, d, ref_mem[1]); else passed++;
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic [11:0] a;
    logic e, ack;
    int lat;
    a = pick_addr();
    suppress_rdata = 1'b1;
    read_word(a, d, e, lat, ack);
`ifdef RAM_INITIATOR_TIMEOUT_EN
    checks++; if (!ack || lat != 1 + 15 || e !== 1'b1 || d !== 32'hFFFF_FFFF) $display("[TB] FAIL timeout: ack=%b lat=%0d err=%b data=%h required ack=1 lat=16 err=1 data=ffffffff", ack, lat, e, d); else passed++;
    suppress_rdata = 1'b0;
    read_word(a, d, e, lat, ack);
    checks++; if (!ack || lat != 3 || e !== 1'b0 || d !== ref_mem[a]) $display("[TB] FAIL after_timeout: ack=%b lat=%0d err=%b data=%h required ack=1 lat=3 err=0 data=%h", ack, lat, e, d, ref_mem[a]); else passed++;
`else
    checks++; if (ack !== 1'b0 || bus_valid !== 1'b0) $display("[TB] FAIL hang_no_ack: ack=%b bus_valid=%b required 0/0", ack, bus_valid); else passed++;
    rd_req = 1'b1; rd_address = a; #1;
    checks++; if (rd_ready !== 1'b0 || e !== 1'b0) $display("[TB] FAIL hang_busy: rd_ready=%b rd_error=%b required 0/0", rd_ready, e); else passed++;
    rd_req = 1'b0;
    @(negedge clk); reset = 1'b1; suppress_rdata = 1'b0;
    @(negedge clk); reset = 1'b0; model_clr();
    @(negedge clk);
    read_word(a, d, e, lat, ack);
    checks++; if (!ack || lat != 3 || d !== ref_mem[a]) $display("[TB] FAIL hang_recover: ack=%b lat=%0d data=%h required ack=1 lat=3 data=%h", ack, lat, d, ref_mem[a]); else passed++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = '0;
      ref_valid[i] = 1'b0;
    end
    $display("[TB] ip_ram_initiator bench start");
    test_reset();
    test_first_write();
    test_readback();
    test_random();
    test_priority();
    test_clr();
    test_stall_reset();
    test_wrap();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
